// File: rtl/bus16_rx_buf.sv
// bus16_rx_buf: elastic receive FIFO for the 16-bit data bus.
// It captures words from the bus driver with a valid/ready handshake and
// presents them in order to the DLX datapath consumer. Occupancy and a
// sticky overflow flag are exposed for debug and flow control.
module bus16_rx_buf #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          IN_VALID,
    input  logic [15:0]   IN_DATA,
    output logic          IN_READY,
    output logic          OUT_VALID,
    output logic [15:0]   OUT_DATA,
    input  logic          OUT_READY,
    output logic [CW-1:0] COUNT,
    output logic          OVF
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          ovf_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Handshake decode; ready/valid come only from registered state (+ reset).
    always_comb begin
        full      = (cnt == CW'(DEPTH));
        empty     = (cnt == '0);
        IN_READY  = RESETN & ~full;
        OUT_VALID = ~empty;
        push      = IN_VALID & IN_READY;
        pop       = OUT_VALID & OUT_READY;
        OUT_DATA  = OUT_VALID ? mem[rp] : '0;
        COUNT     = cnt;
        OVF       = ovf_q;
    end

    // Storage array: written on an accepted push, never cleared by reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wp] <= IN_DATA;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
            if (IN_VALID && !IN_READY) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus16_rx_buf.sv
// Directed testbench for bus16_rx_buf (DEPTH=4) with hand-computed expectations.
module tb_bus16_rx_buf;

    logic        CLK;
    logic        RESETN;
    logic        IN_VALID;
    logic [15:0] IN_DATA;
    logic        IN_READY;
    logic        OUT_VALID;
    logic [15:0] OUT_DATA;
    logic        OUT_READY;
    logic [2:0]  COUNT;
    logic        OVF;

    int unsigned checks;
    int unsigned failures;

    bus16_rx_buf #(.DEPTH(4), .CW(3)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .IN_READY  (IN_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_READY (OUT_READY),
        .COUNT     (COUNT),
        .OVF       (OVF)
    );

    // 10 ns clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        step();
        IN_VALID = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        RESETN    = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 16'h1234;
        OUT_READY = 1'b0;

        // Reset held for two edges with IN_VALID high
        step();
        step();
        check("rst_in_ready", 32'(IN_READY), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_data", 32'(OUT_DATA), 32'h0000);
        check("rst_ovf", 32'(OVF), 32'd0);
        RESETN   = 1'b1;
        IN_VALID = 1'b0;
        #1;
        check("rel_in_ready", 32'(IN_READY), 32'd1);

        // Single word
        push_word(16'hA5C3);
        check("single_valid", 32'(OUT_VALID), 32'd1);
        check("single_data", 32'(OUT_DATA), 32'hA5C3);
        check("single_count", 32'(COUNT), 32'd1);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check("single_pop_count", 32'(COUNT), 32'd0);
        check("single_pop_valid", 32'(OUT_VALID), 32'd0);
        check("single_pop_data", 32'(OUT_DATA), 32'h0000);

        // Pop on empty is ignored
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check("empty_pop_count", 32'(COUNT), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 4; i++) begin
            push_word(16'(i));
        end
        check("full_count", 32'(COUNT), 32'd4);
        check("full_in_ready", 32'(IN_READY), 32'd0);
        check("full_ovf_clear", 32'(OVF), 32'd0);
        push_word(16'h0005);
        check("ovf_set", 32'(OVF), 32'd1);
        check("ovf_count", 32'(COUNT), 32'd4);
        OUT_READY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(OUT_DATA), 32'(i));
            step();
        end
        OUT_READY = 1'b0;
        check("drain_count", 32'(COUNT), 32'd0);
        check("drain_valid", 32'(OUT_VALID), 32'd0);

        // Streaming at COUNT=2 across several pointer wraps
        push_word(16'h0100);
        push_word(16'h0101);
        for (int k = 0; k < 10; k++) begin
            IN_VALID  = 1'b1;
            IN_DATA   = 16'(16'h0102 + k);
            OUT_READY = 1'b1;
            check("stream_data", 32'(OUT_DATA), 32'(16'h0100 + k));
            check("stream_count", 32'(COUNT), 32'd2);
            step();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        check("stream_end_count", 32'(COUNT), 32'd2);
        OUT_READY = 1'b1;
        check("stream_tail0", 32'(OUT_DATA), 32'h010A);
        step();
        check("stream_tail1", 32'(OUT_DATA), 32'h010B);
        step();
        OUT_READY = 1'b0;
        check("stream_empty", 32'(COUNT), 32'd0);
        check("ovf_sticky", 32'(OVF), 32'd1);

        // Pop while full with a held word: only the pop happens
        for (int i = 1; i <= 4; i++) begin
            push_word(16'(16'h0200 + i));
        end
        check("pf_full", 32'(COUNT), 32'd4);
        IN_VALID  = 1'b1;
        IN_DATA   = 16'h0205;
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check("pf_after_pop", 32'(COUNT), 32'd3);
        check("pf_ready_back", 32'(IN_READY), 32'd1);
        check("pf_head", 32'(OUT_DATA), 32'h0202);
        step();
        IN_VALID = 1'b0;
        check("pf_refill", 32'(COUNT), 32'd4);
        OUT_READY = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("pf_drain", 32'(OUT_DATA), 32'(16'h0200 + i));
            step();
        end
        OUT_READY = 1'b0;
        check("pf_empty", 32'(COUNT), 32'd0);

        // Reset mid-stream during a push
        push_word(16'h0301);
        push_word(16'h0302);
        push_word(16'h0303);
        check("mid_count3", 32'(COUNT), 32'd3);
        IN_VALID = 1'b1;
        IN_DATA  = 16'h0304;
        RESETN   = 1'b0;
        step();
        RESETN   = 1'b1;
        IN_VALID = 1'b0;
        check("mid_rst_count", 32'(COUNT), 32'd0);
        check("mid_rst_valid", 32'(OUT_VALID), 32'd0);
        check("mid_rst_ovf", 32'(OVF), 32'd0);
        check("mid_rst_data", 32'(OUT_DATA), 32'h0000);
        push_word(16'hBEEF);
        check("beef_head", 32'(OUT_DATA), 32'hBEEF);
        check("beef_count", 32'(COUNT), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
